arr_wr_sched: RTL and testbench
===============================

Name: arr_wr_sched

Overview:
- Round-robin scheduler that shares one slow write port of a multi-dimensional storage array (DEPTH entries of WIDTH bits) between NREQ requesters.
- Each requester presents a valid/address/data request; the scheduler grants one requester at a time, holds the resource for WR_CYCLES clocks, then acknowledges.
- A single-cycle read port is always available and is not arbitrated.
- Sits between requester blocks and the shared array instance; the array storage lives inside this block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DEPTH, 12, number of array entries.
- WIDTH, 8, bits per entry.
- AW, 4, address width; must satisfy 2**AW >= DEPTH.
- WR_CYCLES, 3, clocks the write port is occupied per granted write (1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester write request, level; held until ack.
- req_addr  input  NREQ*AW  per-requester address, slice i = bits [i*AW +: AW].
- req_data  input  NREQ*WIDTH  per-requester write data, slice i.
- gnt  output  NREQ  one-hot grant, high for the whole write occupancy.
- ack  output  NREQ  one-cycle pulse on completion of requester i's write.
- err  output  NREQ  one-cycle pulse, coincident with ack, when the address was >= DEPTH (write dropped).
- busy  output  1  high while in WRITE state.
- rd_addr  input  AW  read address.
- rd_data  output  WIDTH  registered read data, 1-cycle latency; 0 if rd_addr >= DEPTH.

Behaviour:
- Reset (asynchronous, rst_n low): gnt=0, ack=0, err=0, busy=0, rd_data=0, all entries=0, rr pointer=0, FSM=IDLE, occupancy counter=0.
- FSM states: IDLE, WRITE, DONE.
- IDLE: if any req is high, select the first requester at or after the rr pointer (wrapping modulo NREQ). Latch its addr/data, set gnt bit, load counter=WR_CYCLES-1, go to WRITE. Otherwise stay in IDLE.
- WRITE: busy=1, gnt held. Counter decrements each clock. On the cycle the counter is 0, the entry is written if addr < DEPTH; transition to DONE.
- DONE: single cycle. ack[i]=1, err[i]=(addr>=DEPTH), gnt=0, busy=0. rr pointer=(i+1) mod NREQ. Return to IDLE.
- Throughput: one write per WR_CYCLES+2 clocks. Latency from req rise (in IDLE) to ack is WR_CYCLES+1 clocks.
- Requester data and address are sampled only at grant; later changes are ignored.
- Dropping req while granted does not abort the write; ack is still issued.
- A requester that keeps req high after ack re-enters arbitration at the lowest priority.
- Read: rd_data <= mem[rd_addr] each clock. A read of the address being written in the same cycle returns the old value.
- Simultaneous requests: strict rotation; no requester waits more than NREQ-1 grants.
- Reset mid-WRITE: the write is abandoned, no ack is issued, and the entry is unmodified apart from the reset clear.

Optional Feature:
- Macro: ARR_WR_SCHED_LOCK_EN.
- When defined: adds input lock (NREQ bits).
  - If lock[i] is high in DONE for granted requester i, the rr pointer is not advanced.
  - If req[i] is still high, requester i is re-granted directly from IDLE ahead of the rotation.
  - A lock held for more than 4 consecutive grants is ignored for one arbitration round (anti-starvation).
- When undefined: no lock port; pure round-robin as above.

Test Plan:
- Reset, then single req[1] with addr=5, data=0xA5, WR_CYCLES=3 -> gnt[1] high for 3 clocks, ack[1] 4 clocks after req, rd_addr=5 then reads 0xA5.
- req=4'b1111 held continuously -> grant order 0,1,2,3,0; each ack spaced 5 clocks apart.
- req[2] with addr=13 (>=DEPTH=12) -> ack[2] and err[2] pulse together; a sweep of all entries reads 0.
- Assert rst_n low during WRITE of addr=3, data=0x11 -> outputs clear immediately, no ack, rd of addr 3 returns 0.
- Change req_data[0] from 0x22 to 0x33 one clock after gnt[0] -> entry holds 0x22.
- With LOCK_EN: lock[0]=1, req=4'b0011 -> requester 0 gets 4 grants, then requester 1 is granted, then 0 again.

Source files
------------

// File: rtl/arr_wr_sched_if.sv
// Requester/read bus for arr_wr_sched. Define ARR_WR_SCHED_LOCK_EN to add the per-requester lock input.
// Handshake: req[i] is a level held until ack[i]; addr/data are captured only on the IDLE->WRITE grant edge.
interface arr_wr_sched_if #(
  parameter int NREQ  = 4,
  parameter int AW    = 4,
  parameter int WIDTH = 8
);
  logic [NREQ-1:0]       req;
  logic [NREQ*AW-1:0]    req_addr;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [NREQ-1:0]       err;
  logic                  busy;
  logic [AW-1:0]         rd_addr;
  logic [WIDTH-1:0]      rd_data;
`ifdef ARR_WR_SCHED_LOCK_EN
  logic [NREQ-1:0]       lock;

  modport master (output req, req_addr, req_data, rd_addr, lock,
                  input  gnt, ack, err, busy, rd_data);
  modport slave  (input  req, req_addr, req_data, rd_addr, lock,
                  output gnt, ack, err, busy, rd_data);
`else
  modport master (output req, req_addr, req_data, rd_addr,
                  input  gnt, ack, err, busy, rd_data);
  modport slave  (input  req, req_addr, req_data, rd_addr,
                  output gnt, ack, err, busy, rd_data);
`endif
endinterface

// File: rtl/arr_wr_sched.sv
// Round-robin scheduler for the slow write port of a DEPTH x WIDTH array, plus an unarbitrated 1-cycle read port.
// Optional macro ARR_WR_SCHED_LOCK_EN: lock[i] in DONE keeps the rr pointer on i (max 4 consecutive grants).
module arr_wr_sched #(
  parameter int NREQ      = 4,
  parameter int DEPTH     = 12,
  parameter int WIDTH     = 8,
  parameter int AW        = 4,
  parameter int WR_CYCLES = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  arr_wr_sched_if.slave bus,
  output logic [1:0]   o_dbg_state
);
  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [AW:0]   DEPTH_L  = (AW+1)'(DEPTH);
  localparam logic [3:0]    CNT_LOAD = 4'(WR_CYCLES - 1);
  localparam logic [RW-1:0] LAST_REQ = RW'(NREQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [RW-1:0]    r_rr, w_rr_nxt;
  logic [RW-1:0]    r_sel, w_sel_nxt;
  logic [RW-1:0]    w_pick;
  logic             w_found;
  int               w_idx;
  logic [AW-1:0]    r_addr, w_addr_nxt;
  logic [WIDTH-1:0] r_data, w_data_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             w_addr_ok;
  logic             w_rd_ok;
  logic             w_wr_en;
  logic             w_keep;
  logic [NREQ-1:0]  w_onehot;

  // First requesting index at or after the rr pointer; lowest offset wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr;
    w_idx   = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr) + k) % NREQ;
      if (bus.req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = RW'(w_idx);
      end
    end
  end

`ifdef ARR_WR_SCHED_LOCK_EN
  logic [1:0] r_lock_run, w_lock_run_nxt;

  // A lock survives three re-grants; the fourth DONE advances the pointer anyway.
  assign w_keep = bus.lock[r_sel] && (r_lock_run < 2'd3);

  always_comb begin
    w_lock_run_nxt = r_lock_run;
    if (r_state == S_DONE) begin
      w_lock_run_nxt = w_keep ? (r_lock_run + 2'd1) : 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_run <= 2'd0;
    end else begin
      r_lock_run <= w_lock_run_nxt;
    end
  end
`else
  assign w_keep = 1'b0;
`endif

  assign w_addr_ok = ({1'b0, r_addr} < DEPTH_L);
  assign w_rd_ok   = ({1'b0, bus.rd_addr} < DEPTH_L);
  assign w_wr_en   = (r_state == S_WRITE) && (r_cnt == 4'd0) && w_addr_ok;
  assign w_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << r_sel;

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_sel_nxt   = r_sel;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_sel_nxt   = w_pick;
          w_addr_nxt  = bus.req_addr[w_pick*AW +: AW];
          w_data_nxt  = bus.req_data[w_pick*WIDTH +: WIDTH];
          w_cnt_nxt   = CNT_LOAD;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_DONE: begin
        if (!w_keep) begin
          w_rr_nxt = (r_sel == LAST_REQ) ? '0 : (r_sel + 1'b1);
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rr    <= '0;
      r_sel   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_sel   <= w_sel_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Read samples the array before this edge's write lands, so a same-address read sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_rd_data <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_addr] <= r_data;
      end
      r_rd_data <= w_rd_ok ? r_mem[bus.rd_addr] : '0;
    end
  end

  assign bus.gnt     = (r_state == S_WRITE) ? w_onehot : '0;
  assign bus.ack     = (r_state == S_DONE)  ? w_onehot : '0;
  assign bus.err     = ((r_state == S_DONE) && !w_addr_ok) ? w_onehot : '0;
  assign bus.busy    = (r_state == S_WRITE);
  assign bus.rd_data = r_rd_data;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_arr_wr_sched.sv
// Directed bench for arr_wr_sched (NREQ=4, DEPTH=12, WIDTH=8, AW=4, WR_CYCLES=3); lock steps need ARR_WR_SCHED_LOCK_EN.
module tb_arr_wr_sched;
  localparam int NREQ  = 4;
  localparam int DEPTH = 12;
  localparam int WIDTH = 8;
  localparam int AW    = 4;
  localparam int WRC   = 3;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_errors;
  int         cyc;

  arr_wr_sched_if #(.NREQ(NREQ), .AW(AW), .WIDTH(WIDTH)) bus ();

  arr_wr_sched #(
    .NREQ(NREQ), .DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW), .WR_CYCLES(WRC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // driver tasks
  task automatic drive_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.req_addr[i*AW +: AW]       = a;
    bus.req_data[i*WIDTH +: WIDTH] = d;
    bus.req[i]                     = 1'b1;
  endtask

  task automatic wait_ack(input string tag, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ack == '0 && n < 20);
    check({tag, "_timeout"}, 32'(bus.ack != '0), 32'd1);
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [WIDTH-1:0] exp);
    bus.rd_addr = a;
    tick();
    check(tag, 32'(bus.rd_data), 32'(exp));
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst_n        = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.rd_addr  = '0;
`ifdef ARR_WR_SCHED_LOCK_EN
    bus.lock     = '0;
`endif
    tick();

    // reset state
    check("rst_gnt",   32'(bus.gnt),     32'h0);
    check("rst_ack",   32'(bus.ack),     32'h0);
    check("rst_err",   32'(bus.err),     32'h0);
    check("rst_busy",  32'(bus.busy),    32'h0);
    check("rst_rd",    32'(bus.rd_data), 32'h0);
    check("rst_state", 32'(dbg_state),   32'h0);
    do_reset();

    // single write: requester 1, addr 5, data A5
    drive_req(1, 4'd5, 8'hA5);
    tick();
    check("s1_gnt_c1",  32'(bus.gnt),  32'b0010);
    check("s1_busy_c1", 32'(bus.busy), 32'h1);
    check("s1_state",   32'(dbg_state), 32'h1);
    tick();
    check("s1_gnt_c2",  32'(bus.gnt),  32'b0010);
    tick();
    check("s1_gnt_c3",  32'(bus.gnt),  32'b0010);
    check("s1_ack_early", 32'(bus.ack), 32'h0);
    tick();
    check("s1_gnt_done",  32'(bus.gnt),  32'h0);
    check("s1_busy_done", 32'(bus.busy), 32'h0);
    check("s1_ack",       32'(bus.ack),  32'b0010);
    check("s1_err",       32'(bus.err),  32'h0);
    bus.req = '0;
    tick();
    check("s1_ack_pulse", 32'(bus.ack), 32'h0);
    read_chk("s1_rd5", 4'd5, 8'hA5);

    // all four requesting: strict rotation 0,1,2,3,0 with 5-clock spacing
    do_reset();
    for (int i = 0; i < NREQ; i++) drive_req(i, AW'(i), 8'(8'h10 + i));
    wait_ack("rr0", cyc);
    check("rr0_lat", 32'(cyc),     32'd4);
    check("rr0_ack", 32'(bus.ack), 32'b0001);
    wait_ack("rr1", cyc);
    check("rr1_gap", 32'(cyc),     32'd5);
    check("rr1_ack", 32'(bus.ack), 32'b0010);
    wait_ack("rr2", cyc);
    check("rr2_gap", 32'(cyc),     32'd5);
    check("rr2_ack", 32'(bus.ack), 32'b0100);
    wait_ack("rr3", cyc);
    check("rr3_gap", 32'(cyc),     32'd5);
    check("rr3_ack", 32'(bus.ack), 32'b1000);
    wait_ack("rr4", cyc);
    check("rr4_gap", 32'(cyc),     32'd5);
    check("rr4_ack", 32'(bus.ack), 32'b0001);
    bus.req = '0;
    tick();
    read_chk("rr_rd0", 4'd0, 8'h10);
    read_chk("rr_rd1", 4'd1, 8'h11);
    read_chk("rr_rd2", 4'd2, 8'h12);
    read_chk("rr_rd3", 4'd3, 8'h13);

    // out-of-range write is dropped with err
    do_reset();
    drive_req(2, 4'd13, 8'hEE);
    wait_ack("oor", cyc);
    check("oor_lat", 32'(cyc),     32'd4);
    check("oor_ack", 32'(bus.ack), 32'b0100);
    check("oor_err", 32'(bus.err), 32'b0100);
    bus.req = '0;
    tick();
    check("oor_err_pulse", 32'(bus.err), 32'h0);
    for (int a = 0; a < 16; a++) read_chk($sformatf("oor_sweep%0d", a), AW'(a), 8'h00);

    // reset in the middle of a write
    drive_req(0, 4'd3, 8'h11);
    tick();
    check("mrst_busy", 32'(bus.busy), 32'h1);
    tick();
    rst_n = 1'b0;
    #1;
    check("mrst_gnt",  32'(bus.gnt),  32'h0);
    check("mrst_busy_clr", 32'(bus.busy), 32'h0);
    bus.req = '0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("mrst_noack%0d", k), 32'(bus.ack), 32'h0);
    end
    read_chk("mrst_rd3", 4'd3, 8'h00);

    // data captured at grant; same-cycle read of the written entry sees the old value
    drive_req(0, 4'd7, 8'h22);
    tick();
    check("cap_gnt", 32'(bus.gnt), 32'b0001);
    bus.req_data[7:0] = 8'h33;
    bus.rd_addr       = 4'd7;
    tick();
    tick();
    tick();
    check("cap_ack",    32'(bus.ack),     32'b0001);
    check("cap_rd_old", 32'(bus.rd_data), 32'h00);
    bus.req = '0;
    tick();
    check("cap_rd_new", 32'(bus.rd_data), 32'h22);

`ifdef ARR_WR_SCHED_LOCK_EN
    // lock on requester 0: four grants, then 1, then 0 again
    do_reset();
    bus.lock = 4'b0001;
    drive_req(0, 4'd8, 8'h40);
    drive_req(1, 4'd9, 8'h41);
    for (int g = 0; g < 4; g++) begin
      wait_ack($sformatf("lk%0d", g), cyc);
      check($sformatf("lk%0d_ack", g), 32'(bus.ack), 32'b0001);
    end
    wait_ack("lk4", cyc);
    check("lk4_ack", 32'(bus.ack), 32'b0010);
    wait_ack("lk5", cyc);
    check("lk5_ack", 32'(bus.ack), 32'b0001);
    bus.req  = '0;
    bus.lock = '0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
